// File: rtl/sha256_compress_pkg.sv
// Shared types, constants and SHA-256 bit functions for the compression core.
// Pure declarations; no logic of its own, so no latency.
// No flow control here; users decide how these are sequenced.
package sha256_pkg;

  localparam int WORD_W  = 32;
  localparam int HADDR_W = 3;
  localparam int KADDR_W = 6;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {IDLE, LOAD_H, ROUND, FINAL} state_t;

  localparam logic HSEL = 1'b0;
  localparam logic KSEL = 1'b1;

  // Working variables a..h; a sits in the top word.
  typedef struct packed {
    word_t a, b, c, d, e, f, g, h;
  } wvars_t;

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// Bundles the request/status, constant-memory and schedule-buffer signals.
// Wires only, zero latency.
// Compressor waits on HK_RDY; START is a single-cycle request, never queued.
interface sha256_compress_if;
  logic                        START;
  logic                        CHAIN;
  logic                        HK_RDY;
  logic                        HK_SELECTOR;
  logic [sha256_pkg::HADDR_W-1:0] H_ADDR;
  logic [sha256_pkg::KADDR_W-1:0] K_ADDR;
  sha256_pkg::word_t           HK;
  logic [sha256_pkg::KADDR_W-1:0] W_ADDR;
  sha256_pkg::word_t           W;
  logic                        BUSY;
  logic                        DONE;
  logic                        ERR;
  logic [255:0]                DIGEST;

  // Requester / memory side.
  modport master (
    output START, CHAIN, HK_RDY, HK, W,
    input  HK_SELECTOR, H_ADDR, K_ADDR, W_ADDR, BUSY, DONE, ERR, DIGEST
  );

  // Compressor side.
  modport slave (
    input  START, CHAIN, HK_RDY, HK, W,
    output HK_SELECTOR, H_ADDR, K_ADDR, W_ADDR, BUSY, DONE, ERR, DIGEST
  );
endinterface

// File: rtl/sha256_compress_round.sv
// One SHA-256 round: next a..h from current a..h, K[t] and W[t].
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is registered.
module sha256_round
  import sha256_pkg::*;
(
  input  wvars_t vars_i,
  input  word_t  k_i,
  input  word_t  w_i,
  output wvars_t vars_o
);

  word_t t1, t2;

  assign t1 = vars_i.h + big_sigma1(vars_i.e) + ch(vars_i.e, vars_i.f, vars_i.g) + k_i + w_i;
  assign t2 = big_sigma0(vars_i.a) + maj(vars_i.a, vars_i.b, vars_i.c);

  assign vars_o.a = t1 + t2;
  assign vars_o.b = vars_i.a;
  assign vars_o.c = vars_i.b;
  assign vars_o.d = vars_i.c;
  assign vars_o.e = vars_i.d + t1;
  assign vars_o.f = vars_i.e;
  assign vars_o.g = vars_i.f;
  assign vars_o.h = vars_i.g;

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression of one 512-bit block, optionally chained from the current hash.
// START to DONE: 76 cycles cold (H reload), 67 cycles chained, for 64 rounds.
// HK_RDY low while busy aborts with a one-cycle ERR; START is ignored unless idle and HK_RDY.
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
)(
  input  logic                CLK,
  input  logic                RST_N,
  sha256_compress_if.slave    bus
);

  state_t               state_q, state_d;
  logic [6:0]           cnt_q, cnt_d;
  word_t [7:0]          v_q, v_d;        // index 7 = a ... index 0 = h
  word_t [7:0]          base_q, base_d;  // hash value the block starts from
  word_t [7:0]          h_q, h_d;        // committed hash, index 0 = H0
  logic [255:0]         digest_q, digest_d;
  logic                 sel_q, sel_d;
  logic [HADDR_W-1:0]   haddr_q, haddr_d;
  logic [KADDR_W-1:0]   kaddr_q, kaddr_d;
  logic [KADDR_W-1:0]   waddr_q, waddr_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  wvars_t               cur_vars, nxt_vars;
  logic [2:0]           hidx;

  assign cur_vars = v_q;
  assign hidx     = 3'(cnt_q - 7'd1);

  sha256_round u_round (
    .vars_i (cur_vars),
    .k_i    (bus.HK),
    .w_i    (bus.W),
    .vars_o (nxt_vars)
  );

  // Sequencer: H load, rounds, final add; the base hash is only committed at FINAL
  // so an aborted block leaves H0..H7 and DIGEST untouched.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    v_d      = v_q;
    base_d   = base_q;
    h_d      = h_q;
    digest_d = digest_q;
    sel_d    = sel_q;
    haddr_d  = haddr_q;
    kaddr_d  = kaddr_q;
    waddr_d  = waddr_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START && bus.HK_RDY) begin
          cnt_d = '0;
          if (bus.CHAIN) begin
            state_d = ROUND;
            base_d  = h_q;
            for (int j = 0; j < 8; j++) v_d[7-j] = h_q[j];
            sel_d   = KSEL;
            kaddr_d = '0;
            waddr_d = '0;
          end else begin
            state_d = LOAD_H;
            sel_d   = HSEL;
            haddr_d = '0;
          end
        end
      end
      LOAD_H: begin
        if (cnt_q != 7'd0) begin
          base_d[hidx]       = bus.HK;
          v_d[3'd7 - hidx]   = bus.HK;
        end
        if (cnt_q < 7'd7) haddr_d = 3'(cnt_q + 7'd1);
        if (cnt_q == 7'd8) begin
          state_d = ROUND;
          cnt_d   = '0;
          sel_d   = KSEL;
          kaddr_d = '0;
          waddr_d = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ROUND: begin
        if (cnt_q != 7'd0) v_d = nxt_vars;
        if (cnt_q < 7'(ROUNDS - 1)) begin
          kaddr_d = 6'(cnt_q + 7'd1);
          waddr_d = 6'(cnt_q + 7'd1);
        end
        if (cnt_q == 7'(ROUNDS)) begin
          state_d = FINAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      FINAL: begin
        for (int j = 0; j < 8; j++) h_d[j] = base_q[j] + v_q[7-j];
        for (int j = 0; j < 8; j++) digest_d[255-32*j -: 32] = h_d[j];
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q != IDLE) && !bus.HK_RDY) begin
      state_d  = IDLE;
      cnt_d    = '0;
      h_d      = h_q;
      digest_d = digest_q;
      done_d   = 1'b0;
      err_d    = 1'b1;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      v_q      <= '0;
      base_q   <= '0;
      h_q      <= '0;
      digest_q <= '0;
      sel_q    <= HSEL;
      haddr_q  <= '0;
      kaddr_q  <= '0;
      waddr_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      v_q      <= v_d;
      base_q   <= base_d;
      h_q      <= h_d;
      digest_q <= digest_d;
      sel_q    <= sel_d;
      haddr_q  <= haddr_d;
      kaddr_q  <= kaddr_d;
      waddr_q  <= waddr_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.BUSY        = (state_q != IDLE);
  assign bus.DONE        = done_q;
  assign bus.ERR         = err_q;
  assign bus.HK_SELECTOR = sel_q;
  assign bus.H_ADDR      = haddr_q;
  assign bus.K_ADDR      = kaddr_q;
  assign bus.W_ADDR      = waddr_q;
  assign bus.DIGEST      = digest_q;

endmodule

// File: doc/sha256_compress.md
Name: sha256_compress

Overview:
- Downstream consumer of the H/K constant memory; runs the SHA-256 compression function over one 512-bit block.
- Loads H0..H7 from the constant memory, then runs ROUNDS rounds. Each round fetches K[t] from the constant memory and W[t] from the message-schedule buffer.
- At the end it adds the working variables back into the hash state and presents the 256-bit digest.
- Supports chained multi-block messages by reusing the previous hash state instead of reloading H constants.

Parameters:
- ROUNDS, 64, number of compression rounds; legal range 1..64; values below 64 are for bench reduction only.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST_N  in  1  synchronous active-low reset.
- START  in  1  single-cycle request to compress one block.
- CHAIN  in  1  sampled with START; 1 = continue from current hash state, skip H load.
- HK_RDY  in  1  constant memory ready (ROM copy finished).
- HK_SELECTOR  out  1  0 = H bank, 1 = K bank.
- H_ADDR  out  3  H constant index.
- K_ADDR  out  6  K constant index.
- HK  in  32  constant memory read data; valid one cycle after address.
- W_ADDR  out  6  message-schedule word index.
- W  in  32  schedule read data; valid one cycle after W_ADDR.
- BUSY  out  1  high from accepted START until DONE/ERR cycle.
- DONE  out  1  one-cycle pulse; DIGEST valid and updated.
- ERR  out  1  one-cycle pulse; operation aborted.
- DIGEST  out  256  {H0..H7}, H0 in bits 255:224.

Behaviour:
- Reset (RST_N low at an edge, any state): state IDLE; BUSY/DONE/ERR = 0; HK_SELECTOR = 0; H_ADDR/K_ADDR/W_ADDR = 0; H0..H7, a..h and DIGEST = 0. Reset mid-operation abandons the block silently, with no ERR.
- IDLE:
  - START && HK_RDY → accepted.
  - If CHAIN = 1, go to ROUND and load a..h from H0..H7 at the same edge.
  - If CHAIN = 0, go to LOAD_H.
  - START while !HK_RDY is ignored and not queued. START while BUSY is ignored.
- LOAD_H (9 cycles, index i = 0..8):
  - HK_SELECTOR = 0, H_ADDR = i for i ≤ 7.
  - At cycles i ≥ 1, capture HK into H[i-1] and the matching working variable a..h.
  - After cycle 8, go to ROUND.
- ROUND (ROUNDS+1 cycles, index c = 0..ROUNDS):
  - HK_SELECTOR = 1; K_ADDR = W_ADDR = c for c < ROUNDS.
  - At c ≥ 1, apply round t = c-1 using the HK and W read data:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K + W; T2 = Σ0(a) + Maj(a,b,c).
    - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - All additions mod 2^32.
  - After c = ROUNDS, go to FINAL.
- FINAL (1 cycle): Hn ← Hn + var_n mod 2^32, DIGEST ← new {H0..H7}; go to IDLE with DONE = 1 and BUSY = 0 on the following cycle.
- Latency from the START-sampling edge to DONE high:
  - 76 cycles cold (CHAIN = 0, ROUNDS = 64).
  - 67 cycles chained.
- HK_RDY falling while BUSY: at the next edge go to IDLE and pulse ERR. H0..H7 and DIGEST keep their pre-START values.
- Between operations, DIGEST and H0..H7 hold their values. CHAIN with no prior block uses the reset value 0 (legal, defined).
- Address outputs hold their last value in IDLE.

Decomposition:
- sha256_pkg holds:
  - state enum (IDLE, LOAD_H, ROUND, FINAL);
  - HSEL = 0 and KSEL = 1 constants;
  - functions Σ0, Σ1, Ch, Maj;
  - word width 32 and address widths 3/6.
- Sub-module sha256_round: purely combinational. Inputs a..h, K, W; outputs next a..h. It is instantiated once.

Test Plan:
- Cold start with the constant memory model and the "abc" padded schedule → DONE exactly 76 cycles after START. DIGEST = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty-string block → DIGEST = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855. Also check the address trace: H_ADDR 0..7 with HSEL, then K_ADDR = W_ADDR = 0..63 with KSEL.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with CHAIN = 0, block 2 with CHAIN = 1. Block 2 shows no H fetch and DONE 67 cycles after START. DIGEST = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- START pulsed while HK_RDY = 0 → BUSY stays 0 and no address activity. A later START with HK_RDY = 1 completes normally.
- Drop HK_RDY at ROUND cycle 30 → ERR pulse for 1 cycle, BUSY = 0, DIGEST unchanged from the previous "abc" result.
- Assert RST_N low at ROUND cycle 40 → all outputs 0 next cycle, no DONE or ERR. A subsequent cold "abc" run gives the correct digest.
